// File: rtl/conv1d_pkg.sv
// rtl/conv1d_pkg.sv - shared constants and state encoding for the conv1d scheduler
// Purpose: data width, filter tap count and the scheduler FSM state type.
package conv1d_pkg;

    localparam int BW          = 8;
    localparam int FILTER_SIZE = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WLOAD = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - saturating up-counter with explicit clear and terminal flag
// Purpose: counts 0..MAX; holds at MAX instead of rolling over, returns to 0 only on clr_i.
// Ports:
//   clk_i    clock
//   rst_i_n  asynchronous active-low reset
//   clr_i    synchronous clear (wins over en_i)
//   en_i     increment enable
//   count_o  current count
//   at_max_o count_o == MAX
module wrap_counter #(
    parameter int MAX = 4,
    parameter int BW  = 3
) (
    input  logic          clk_i,
    input  logic          rst_i_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [BW-1:0] count_o,
    output logic          at_max_o
);

    assign at_max_o = (count_o == BW'(MAX));

    always_ff @(posedge clk_i or negedge rst_i_n) begin
        if (!rst_i_n) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (en_i && !at_max_o) begin
            count_o <= count_o + BW'(1);
        end
    end

endmodule

// File: rtl/conv1d_sched.sv
// rtl/conv1d_sched.sv - frame load / filter replay scheduler for the 1D convolution datapath
// Purpose: writes one input frame into the frame buffer, then replays it once per filter,
// pulsing a weight load before each pass and issuing reads with tap sideband.
// Ports:
//   clk_i, rst_i_n          clock, asynchronous active-low reset
//   valid_i, last_i         upstream beat handshake, ready_o returned
//   buf_wr_en_o, buf_rd_en_o, buf_addr_o   frame buffer control (shared address)
//   wt_ld_o, wt_idx_o       weight bank load strobe and filter index
//   tap_valid_o, pass_last_o, frame_last_o read sideband to the MAC pipeline
//   ready_i                 downstream ready, stalls reads while low
//   frame_err_o             one-cycle pulse after a frame of the wrong length
//   busy_o                  scheduler not idle
module conv1d_sched
    import conv1d_pkg::*;
#(
    parameter  int FRAME_SIZE  = 50,
    parameter  int NUM_FILTERS = 8,
    localparam int ADDR_BW     = $clog2(FRAME_SIZE),
    localparam int FILT_BW     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i_n,
    input  logic               valid_i,
    input  logic               last_i,
    output logic               ready_o,
    output logic               buf_wr_en_o,
    output logic               buf_rd_en_o,
    output logic [ADDR_BW-1:0] buf_addr_o,
    output logic               wt_ld_o,
    output logic [FILT_BW-1:0] wt_idx_o,
    output logic               tap_valid_o,
    output logic               pass_last_o,
    output logic               frame_last_o,
    input  logic               ready_i,
    output logic               frame_err_o,
    output logic               busy_o
);

    state_t             state;
    logic [ADDR_BW-1:0] addr;
    logic [FILT_BW-1:0] filt;
    logic               addr_max;
    logic               filt_max;
    logic               xfer;
    logic               issue;
    logic               pass_end;
    logic               short_err;
    logic               load_done;
    logic               addr_clr;
    logic               addr_en;
    logic               filt_clr;
    logic               filt_en;

    assign ready_o   = (state == IDLE) || (state == LOAD);
    assign xfer      = valid_i && ready_o;
    assign issue     = (state == RUN) && ready_i;
    assign pass_end  = issue && addr_max;

    // FRAME_SIZE > FILTER_SIZE guarantees address 0 is never the terminal count,
    // so a last beat in IDLE falls into the short-frame case as well.
    assign short_err = xfer && last_i && !addr_max;
    assign load_done = (state == LOAD) && xfer && addr_max;

    // One counter serves as write pointer during load and read pointer during
    // replay; it is cleared at every phase boundary so each pass starts at 0.
    assign addr_en   = xfer || issue;
    assign addr_clr  = short_err || load_done || (state == WLOAD) || pass_end;
    assign filt_en   = pass_end && !filt_max;
    assign filt_clr  = load_done || (pass_end && filt_max);

    wrap_counter #(
        .MAX (FRAME_SIZE - 1),
        .BW  (ADDR_BW)
    ) u_addr_cnt (
        .clk_i    (clk_i),
        .rst_i_n  (rst_i_n),
        .clr_i    (addr_clr),
        .en_i     (addr_en),
        .count_o  (addr),
        .at_max_o (addr_max)
    );

    wrap_counter #(
        .MAX (NUM_FILTERS - 1),
        .BW  (FILT_BW)
    ) u_filt_cnt (
        .clk_i    (clk_i),
        .rst_i_n  (rst_i_n),
        .clr_i    (filt_clr),
        .en_i     (filt_en),
        .count_o  (filt),
        .at_max_o (filt_max)
    );

    always_ff @(posedge clk_i or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state       <= IDLE;
            frame_err_o <= 1'b0;
        end else begin
            // A frame reaching full length without last_i is still processed,
            // but flagged; the extra upstream beats are never accepted.
            frame_err_o <= short_err || (load_done && !last_i);
            case (state)
                IDLE: begin
                    if (xfer && !last_i) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (short_err) begin
                        state <= IDLE;
                    end else if (load_done) begin
                        state <= WLOAD;
                    end
                end
                WLOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (pass_end) begin
                        state <= filt_max ? IDLE : WLOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign buf_wr_en_o  = xfer;
    assign buf_rd_en_o  = issue;
    assign buf_addr_o   = addr;
    assign wt_ld_o      = (state == WLOAD);
    assign wt_idx_o     = filt;
    assign tap_valid_o  = issue && (addr >= ADDR_BW'(FILTER_SIZE - 1));
    assign pass_last_o  = pass_end;
    assign frame_last_o = pass_end && filt_max;
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_conv1d_sched.sv
// tb/tb_conv1d_sched.sv - directed self-checking bench for conv1d_sched
module tb_conv1d_sched;

    logic clk;
    logic rst_n;

    // small instance: FRAME_SIZE=5, NUM_FILTERS=2
    logic       s_valid, s_last, s_ready_in;
    logic       s_ready, s_wr, s_rd, s_ld, s_tap, s_pl, s_fl, s_err, s_busy;
    logic [2:0] s_addr;
    logic [0:0] s_idx;

    // default instance: FRAME_SIZE=50, NUM_FILTERS=8
    logic       d_valid, d_last, d_ready_in;
    logic       d_ready, d_wr, d_rd, d_ld, d_tap, d_pl, d_fl, d_err, d_busy;
    logic [5:0] d_addr;
    logic [2:0] d_idx;

    int checks;
    int failures;

    logic [12:0] obs_s;
    logic [12:0] exp_s;

    conv1d_sched #(.FRAME_SIZE(5), .NUM_FILTERS(2)) dut_s (
        .clk_i(clk), .rst_i_n(rst_n), .valid_i(s_valid), .last_i(s_last),
        .ready_o(s_ready), .buf_wr_en_o(s_wr), .buf_rd_en_o(s_rd), .buf_addr_o(s_addr),
        .wt_ld_o(s_ld), .wt_idx_o(s_idx), .tap_valid_o(s_tap), .pass_last_o(s_pl),
        .frame_last_o(s_fl), .ready_i(s_ready_in), .frame_err_o(s_err), .busy_o(s_busy)
    );

    conv1d_sched dut_d (
        .clk_i(clk), .rst_i_n(rst_n), .valid_i(d_valid), .last_i(d_last),
        .ready_o(d_ready), .buf_wr_en_o(d_wr), .buf_rd_en_o(d_rd), .buf_addr_o(d_addr),
        .wt_ld_o(d_ld), .wt_idx_o(d_idx), .tap_valid_o(d_tap), .pass_last_o(d_pl),
        .frame_last_o(d_fl), .ready_i(d_ready_in), .frame_err_o(d_err), .busy_o(d_busy)
    );

    assign obs_s = {s_ready, s_wr, s_rd, s_addr, s_ld, s_idx, s_tap, s_pl, s_fl, s_err, s_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ev(bit rdy, bit wr, bit rd, int addr, bit ld, int idx,
                                       bit tap, bit pl, bit fl, bit err, bit busy);
        return {rdy, wr, rd, 3'(addr), ld, 1'(idx), tap, pl, fl, err, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 0; s_last = 0; s_ready_in = 1;
        d_valid = 0; d_last = 0; d_ready_in = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_s = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL reset_small obs=%b exp=%b", obs_s, exp_s);
        end
        checks++;
        if ({d_ready, d_busy, d_addr, d_idx, d_err} !== {1'b1, 1'b0, 6'd0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_default ready=%b busy=%b addr=%0d idx=%0d err=%b exp 1 0 0 0 0",
                     d_ready, d_busy, d_addr, d_idx, d_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Full frame on the small instance: 5 load beats, then 2 x (WLOAD + 5 reads),
    // optional 3-cycle downstream stall at read address stall_at of filter 0.
    task automatic test_frame(input bit missing_last, input int stall_at);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1;
            s_last  = (i == 4) && !missing_last;
            @(negedge clk);
            exp_s = ev(1, 1, 0, i, 0, 0, 0, 0, 0, 0, i > 0);
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL load beat=%0d obs=%b exp=%b", i, obs_s, exp_s);
            end
            step();
        end
        s_valid = 0;
        s_last  = 0;
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            exp_s = ev(0, 0, 0, 0, 1, f, 0, 0, 0, missing_last && (f == 0), 1);
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL wload f=%0d obs=%b exp=%b", f, obs_s, exp_s);
            end
            step();
            for (int j = 0; j < 5; j++) begin
                if (f == 0 && j == stall_at) begin
                    s_ready_in = 0;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        exp_s = ev(0, 0, 0, j, 0, f, 0, 0, 0, 0, 1);
                        checks++;
                        if (obs_s !== exp_s) begin
                            failures++;
                            $display("FAIL stall k=%0d obs=%b exp=%b", k, obs_s, exp_s);
                        end
                        step();
                    end
                    s_ready_in = 1;
                end
                @(negedge clk);
                exp_s = ev(0, 0, 1, j, 0, f, j >= 2, j == 4, (j == 4) && (f == 1), 0, 1);
                checks++;
                if (obs_s !== exp_s) begin
                    failures++;
                    $display("FAIL read f=%0d addr=%0d obs=%b exp=%b", f, j, obs_s, exp_s);
                end
                step();
            end
        end
        @(negedge clk);
        exp_s = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL frame_idle obs=%b exp=%b", obs_s, exp_s);
        end
        step();
    endtask

    task automatic test_clean_frame();
        test_frame(0, -1);
    endtask

    task automatic test_short_frame();
        // single beat with last in IDLE
        s_valid = 1;
        s_last  = 1;
        @(negedge clk);
        exp_s = ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL single_beat obs=%b exp=%b", obs_s, exp_s);
        end
        step();
        s_valid = 0;
        s_last  = 0;
        @(negedge clk);
        exp_s = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL single_beat_err obs=%b exp=%b", obs_s, exp_s);
        end
        step();
        // three beats, last on the third
        for (int i = 0; i < 3; i++) begin
            s_valid = 1;
            s_last  = (i == 2);
            @(negedge clk);
            exp_s = ev(1, 1, 0, i, 0, 0, 0, 0, 0, 0, i > 0);
            checks++;
            if (obs_s !== exp_s) begin
                failures++;
                $display("FAIL short_beat=%0d obs=%b exp=%b", i, obs_s, exp_s);
            end
            step();
        end
        s_valid = 0;
        s_last  = 0;
        @(negedge clk);
        exp_s = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL short_err obs=%b exp=%b", obs_s, exp_s);
        end
        step();
        @(negedge clk);
        exp_s = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL short_after obs=%b exp=%b", obs_s, exp_s);
        end
        step();
        test_frame(0, -1);
    endtask

    task automatic test_missing_last();
        test_frame(1, -1);
    endtask

    task automatic test_backpressure();
        test_frame(0, 2);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1;
            s_last  = (i == 4);
            step();
        end
        s_valid = 0;
        s_last  = 0;
        repeat (6 + 1 + 3) step();
        @(negedge clk);
        exp_s = ev(0, 0, 1, 3, 0, 1, 1, 0, 0, 0, 1);
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL pre_reset obs=%b exp=%b", obs_s, exp_s);
        end
        #1;
        rst_n = 1'b0;
        #1;
        exp_s = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_s !== exp_s) begin
            failures++;
            $display("FAIL async_reset obs=%b exp=%b", obs_s, exp_s);
        end
        step();
        rst_n = 1'b1;
        test_frame(0, -1);
    endtask

    task automatic test_default_random();
        int n_ld, n_tap, n_pl, n_fl, n_rd, rd_exp;
        bit done;
        n_ld = 0; n_tap = 0; n_pl = 0; n_fl = 0; n_rd = 0; rd_exp = 0; done = 0;
        for (int i = 0; i < 50; i++) begin
            d_valid = 1;
            d_last  = (i == 49);
            @(negedge clk);
            checks++;
            if ({d_wr, d_addr} !== {1'b1, 6'(i)}) begin
                failures++;
                $display("FAIL dflt_load beat=%0d wr=%b addr=%0d exp wr=1 addr=%0d", i, d_wr, d_addr, i);
            end
            step();
        end
        d_valid = 0;
        d_last  = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            d_ready_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!d_busy) begin
                done = 1;
                break;
            end
            if (d_ld) begin
                checks++;
                if (d_idx !== 3'(n_ld)) begin
                    failures++;
                    $display("FAIL dflt_wt_idx got=%0d exp=%0d", d_idx, n_ld);
                end
                n_ld++;
            end
            if (d_rd) begin
                checks++;
                if (d_addr !== 6'(rd_exp)) begin
                    failures++;
                    $display("FAIL dflt_rd_addr got=%0d exp=%0d", d_addr, rd_exp);
                end
                rd_exp = (rd_exp == 49) ? 0 : rd_exp + 1;
                n_rd++;
            end
            n_tap += int'(d_tap);
            n_pl  += int'(d_pl);
            n_fl  += int'(d_fl);
            step();
        end
        d_ready_in = 1;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL dflt_timeout busy=%b exp 0 within budget", d_busy);
        end
        checks++;
        if (n_ld != 8) begin
            failures++;
            $display("FAIL dflt_wt_ld got=%0d exp=8", n_ld);
        end
        checks++;
        if (n_tap != 384) begin
            failures++;
            $display("FAIL dflt_tap got=%0d exp=384", n_tap);
        end
        checks++;
        if (n_pl != 8) begin
            failures++;
            $display("FAIL dflt_pass_last got=%0d exp=8", n_pl);
        end
        checks++;
        if (n_fl != 1) begin
            failures++;
            $display("FAIL dflt_frame_last got=%0d exp=1", n_fl);
        end
        checks++;
        if (n_rd != 400) begin
            failures++;
            $display("FAIL dflt_reads got=%0d exp=400", n_rd);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_clean_frame();
        test_short_frame();
        test_missing_last();
        test_backpressure();
        test_async_reset();
        test_default_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
